rtc_bus_responder: RTL and testbench
====================================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000; clk cycles per one-second time advance.
REQ-002 SHALL have port clk, input, 1 bit; single clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-low reset.
REQ-004 SHALL have port CS, input, 1 bit; chip select, active-low.
REQ-005 SHALL have port RD, input, 1 bit; read strobe, active-low.
REQ-006 SHALL have port WR, input, 1 bit; write strobe, active-low.
REQ-007 SHALL have port A_D, input, 1 bit; 0 = address phase, 1 = data phase.
REQ-008 SHALL have port io_port, inout, 8 bits; multiplexed address/data bus, high-Z unless driving a read.
REQ-009 SHALL have port timer_done, output, 1 bit; mirrors STATUS bit0.

Function
REQ-010 SHALL pass CS, RD, WR, A_D through two-flop synchronizers; all decode SHALL use second-stage values (cs_s, rd_s, wr_s, ad_s).
REQ-011 SHALL detect a write event on the rising edge of wr_s (previous 0, current 1) with cs_s=0; io_port SHALL be sampled through one register stage aligned with wr_s.
REQ-012 Write event with ad_s=0 SHALL load the 8-bit address register.
REQ-013 Write event with ad_s=1 SHALL write the sampled byte to the register at the address register.
REQ-014 SHALL drive io_port with the addressed register value whenever cs_s=0, rd_s=0, ad_s=1; otherwise io_port SHALL be high-Z.
REQ-015 Register map: 0x00 STATUS (bit0 timer_done, bit1 halt), 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 tmr_sec, 0x42 tmr_min, 0x43 tmr_hour; all time values are packed BCD.
REQ-016 Reads of unmapped addresses SHALL return 0x00; writes to unmapped addresses SHALL be ignored.
REQ-017 Writing STATUS SHALL set halt from data bit1; data bit0=1 SHALL clear timer_done; data bit0=0 SHALL leave it unchanged.
REQ-018 A prescaler SHALL count 0..TICKS_PER_SEC-1 and assert a one-cycle tick when wrapping to 0.
REQ-019 While halt=1 the prescaler SHALL hold and no tick SHALL occur.
REQ-020 On tick, sec SHALL BCD-increment. Wraps: sec 59->00 carries to min. Min 59->00 carries to hour. Hour 23->00 carries to day. Day 31->01 carries to month. Month 12->01 carries to year. Year 99->00 with no further carry.
REQ-021 BCD increment SHALL be: low nibble 9 -> 0 with +1 to high nibble, otherwise low nibble +1; wrap SHALL be tested by equality with the limit before incrementing.
REQ-022 Month-length and leap-year rules SHALL NOT be applied (day range 01..31 for all months).
REQ-023 On tick, if timer {hour,min,sec} is non-zero, it SHALL BCD-decrement one second. Borrows: sec 00->59 borrows min; min 00->59 borrows hour.
REQ-024 When a decrement yields 00:00:00, timer_done SHALL be set in that same tick cycle; when the timer is already zero it SHALL stay zero and timer_done SHALL be unchanged.
REQ-025 If a bus write to a register coincides with a tick, the bus write SHALL win for that register; carries/borrows into other registers SHALL still apply.
REQ-026 A tick coinciding with a STATUS write having bit0=1 and the timer reaching zero SHALL leave timer_done=1 (set wins).
REQ-027 Non-BCD values written SHALL be stored unmodified; subsequent increment and decrement SHALL follow REQ-021/023 nibble rules without correction.

Reset
REQ-028 When reset=0 at a clk edge, all registers SHALL be 0x00, except day=0x01 and month=0x01. Prescaler, address register and synchronizers SHALL clear, with synchronizers clearing to the inactive value 1.
REQ-029 During and after reset, io_port SHALL be high-Z and timer_done SHALL be 0 until a qualifying event occurs.
REQ-030 Reset asserted mid-transaction SHALL abort it; a WR rising edge in the first cycle after reset release SHALL NOT be treated as a write event.

Verification (TICKS_PER_SEC=4 unless stated)
REQ-031 Address 0x22 write, data 0x37 write, then read 0x22 -> io_port=0x37 while RD low, high-Z within 3 clk of RD high.
REQ-032 Set sec/min/hour/day/month/year = 59/59/23/31/12/99, run 4 clk -> all read 00/00/00/01/01/00.
REQ-033 Timer = 00:01:00, run 60 ticks -> tmr regs 00, timer_done=1. Write STATUS=0x01 -> timer_done=0.
REQ-034 Write STATUS=0x02, run 20 clk -> sec unchanged. Write STATUS=0x00 -> sec advances every 4 clk.
REQ-035 Read 0x7F -> 0x00. Write 0x7F with 0xAA -> all mapped registers unchanged.
REQ-036 Assert reset during a data-phase write, then release -> registers at reset values; no write occurs.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Real-time clock and countdown timer behind an asynchronous 8-bit multiplexed
// address/data bus. Time and timer registers are packed BCD; a prescaler turns
// TICKS_PER_SEC clock cycles into one-second ticks.
module rtc_bus_responder #(
  parameter int unsigned TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic       A_D,
  inout  wire  [7:0] io_port,
  output logic       timer_done
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  localparam logic [7:0] ADDR_STATUS   = 8'h00;
  localparam logic [7:0] ADDR_SEC      = 8'h21;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_HOUR     = 8'h23;
  localparam logic [7:0] ADDR_DAY      = 8'h24;
  localparam logic [7:0] ADDR_MONTH    = 8'h25;
  localparam logic [7:0] ADDR_YEAR     = 8'h26;
  localparam logic [7:0] ADDR_TMR_SEC  = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN  = 8'h42;
  localparam logic [7:0] ADDR_TMR_HOUR = 8'h43;

  // Synchronizer stages and bus capture
  logic cs_q, rd_q, wr_q, ad_q;
  logic cs_s, rd_s, wr_s, ad_s;
  logic wr_prev;
  logic [7:0] data_s;
  logic [7:0] addr;

  // Architectural state
  logic [7:0] sec, min, hour, day, month, year;
  logic [7:0] tmr_sec, tmr_min, tmr_hour;
  logic       halt;
  logic [PW-1:0] presc;

  // Next-state values
  logic [7:0] sec_n, min_n, hour_n, day_n, month_n, year_n;
  logic [7:0] tmr_sec_n, tmr_min_n, tmr_hour_n;
  logic       halt_n, done_n, done_set, done_clr;

  logic tick_c, wr_ev_c, wr_addr_c, wr_data_c, drive_c;
  logic [7:0] rd_val_c;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_inc = (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    bcd_dec = (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : {v[7:4], v[3:0] - 4'h1};
  endfunction

  assign tick_c    = !halt && (presc == PRESC_LAST);
  assign wr_ev_c   = !cs_s && !wr_prev && wr_s;
  assign wr_addr_c = wr_ev_c && !ad_s;
  assign wr_data_c = wr_ev_c && ad_s;
  assign drive_c   = !cs_s && !rd_s && ad_s;

  assign io_port = drive_c ? rd_val_c : 8'hzz;

  // Read mux: unmapped addresses read as zero
  always_comb begin
    rd_val_c = 8'h00;
    case (addr)
      ADDR_STATUS:   rd_val_c = {6'b0, halt, timer_done};
      ADDR_SEC:      rd_val_c = sec;
      ADDR_MIN:      rd_val_c = min;
      ADDR_HOUR:     rd_val_c = hour;
      ADDR_DAY:      rd_val_c = day;
      ADDR_MONTH:    rd_val_c = month;
      ADDR_YEAR:     rd_val_c = year;
      ADDR_TMR_SEC:  rd_val_c = tmr_sec;
      ADDR_TMR_MIN:  rd_val_c = tmr_min;
      ADDR_TMR_HOUR: rd_val_c = tmr_hour;
      default:       rd_val_c = 8'h00;
    endcase
  end

  // Tick-driven calendar/timer advance, then bus writes override their target
  always_comb begin
    sec_n      = sec;
    min_n      = min;
    hour_n     = hour;
    day_n      = day;
    month_n    = month;
    year_n     = year;
    tmr_sec_n  = tmr_sec;
    tmr_min_n  = tmr_min;
    tmr_hour_n = tmr_hour;
    halt_n     = halt;
    done_set   = 1'b0;
    done_clr   = 1'b0;

    if (tick_c) begin
      if (sec == 8'h59) begin
        sec_n = 8'h00;
        if (min == 8'h59) begin
          min_n = 8'h00;
          if (hour == 8'h23) begin
            hour_n = 8'h00;
            if (day == 8'h31) begin
              day_n = 8'h01;
              if (month == 8'h12) begin
                month_n = 8'h01;
                year_n  = (year == 8'h99) ? 8'h00 : bcd_inc(year);
              end else begin
                month_n = bcd_inc(month);
              end
            end else begin
              day_n = bcd_inc(day);
            end
          end else begin
            hour_n = bcd_inc(hour);
          end
        end else begin
          min_n = bcd_inc(min);
        end
      end else begin
        sec_n = bcd_inc(sec);
      end

      if ({tmr_hour, tmr_min, tmr_sec} != 24'h0) begin
        if (tmr_sec == 8'h00) begin
          tmr_sec_n = 8'h59;
          if (tmr_min == 8'h00) begin
            tmr_min_n  = 8'h59;
            tmr_hour_n = bcd_dec(tmr_hour);
          end else begin
            tmr_min_n = bcd_dec(tmr_min);
          end
        end else begin
          tmr_sec_n = bcd_dec(tmr_sec);
        end
        done_set = ({tmr_hour_n, tmr_min_n, tmr_sec_n} == 24'h0);
      end
    end

    if (wr_data_c) begin
      case (addr)
        ADDR_STATUS: begin
          halt_n   = data_s[1];
          done_clr = data_s[0];
        end
        ADDR_SEC:      sec_n      = data_s;
        ADDR_MIN:      min_n      = data_s;
        ADDR_HOUR:     hour_n     = data_s;
        ADDR_DAY:      day_n      = data_s;
        ADDR_MONTH:    month_n    = data_s;
        ADDR_YEAR:     year_n     = data_s;
        ADDR_TMR_SEC:  tmr_sec_n  = data_s;
        ADDR_TMR_MIN:  tmr_min_n  = data_s;
        ADDR_TMR_HOUR: tmr_hour_n = data_s;
        default: ;
      endcase
    end

    // Timer expiry outranks a simultaneous software clear
    done_n = done_set ? 1'b1 : (done_clr ? 1'b0 : timer_done);
  end

  // Bus synchronizers, write-edge history and data capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      cs_s    <= 1'b1;
      rd_s    <= 1'b1;
      wr_s    <= 1'b1;
      ad_s    <= 1'b1;
      wr_prev <= 1'b1;
      data_s  <= 8'h00;
      addr    <= 8'h00;
    end else begin
      cs_q    <= CS;
      rd_q    <= RD;
      wr_q    <= WR;
      ad_q    <= A_D;
      cs_s    <= cs_q;
      rd_s    <= rd_q;
      wr_s    <= wr_q;
      ad_s    <= ad_q;
      wr_prev <= wr_s;
      data_s  <= io_port;
      if (wr_addr_c) addr <= data_s;
    end
  end

  // Prescaler, holds while halted
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (!halt) begin
      presc <= tick_c ? '0 : presc + PW'(1);
    end
  end

  // Register file update
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec        <= 8'h00;
      min        <= 8'h00;
      hour       <= 8'h00;
      day        <= 8'h01;
      month      <= 8'h01;
      year       <= 8'h00;
      tmr_sec    <= 8'h00;
      tmr_min    <= 8'h00;
      tmr_hour   <= 8'h00;
      halt       <= 1'b0;
      timer_done <= 1'b0;
    end else begin
      sec        <= sec_n;
      min        <= min_n;
      hour       <= hour_n;
      day        <= day_n;
      month      <= month_n;
      year       <= year_n;
      tmr_sec    <= tmr_sec_n;
      tmr_min    <= tmr_min_n;
      tmr_hour   <= tmr_hour_n;
      halt       <= halt_n;
      timer_done <= done_n;
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 4-cycle second. Time only moves
// inside run windows whose length is a multiple of the prescaler period, so
// every window advances by an exact number of seconds.
module tb_rtc_bus_responder;

  localparam int unsigned TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, ad = 1'b0;
  logic       bus_oe = 1'b0;
  logic [7:0] bus_drv = 8'h00;
  wire  [7:0] io_port;
  logic       timer_done;

  int n_checks = 0;
  int n_fail   = 0;

  assign io_port = bus_oe ? bus_drv : 8'hzz;

  // Undriven bus reads as 0xFF
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (io_port[i]);
  end

  rtc_bus_responder #(.TICKS_PER_SEC(TPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .CS        (cs),
    .RD        (rd),
    .WR        (wr),
    .A_D       (ad),
    .io_port   (io_port),
    .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One bus write cycle (11 clocks); the register update lands on the 8th posedge
  task automatic bus_write(input logic phase, input logic [7:0] data);
    cs = 1'b0; ad = phase; bus_oe = 1'b1; bus_drv = data;
    cyc(2);
    wr = 1'b0;
    cyc(3);
    wr = 1'b1;
    cyc(4);
    cs = 1'b1; bus_oe = 1'b0;
    cyc(2);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus_write(1'b0, a);
    bus_write(1'b1, d);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
    bus_write(1'b0, a);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    cyc(4);
    v = io_port;
    rd = 1'b1;
    cyc(3);
    cs = 1'b1;
    cyc(2);
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    read_reg(a, v);
    check_eq(tag, v, exp);
  endtask

  // Unhalt for exactly 4*n clocks (n >= 3), then halt again: n seconds pass
  task automatic run_ticks(input int n);
    bus_write(1'b0, 8'h00);
    bus_write(1'b1, 8'h00);
    cyc(4 * n - 11);
    bus_write(1'b1, 8'h02);
  endtask

  // Reset, then halt as fast as possible: the halt write lands 19 clocks after
  // release, so 4 seconds have elapsed and the prescaler parks at 3.
  task automatic reset_and_halt();
    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b0; bus_oe = 1'b0;
    cyc(3);
    reset = 1'b1;
    bus_write(1'b0, 8'h00);
    bus_write(1'b1, 8'h02);
  endtask

  task automatic check_reset_state(input string pfx);
    chk_reg({pfx, "_sec"},   8'h21, 8'h04);
    chk_reg({pfx, "_min"},   8'h22, 8'h00);
    chk_reg({pfx, "_hour"},  8'h23, 8'h00);
    chk_reg({pfx, "_day"},   8'h24, 8'h01);
    chk_reg({pfx, "_month"}, 8'h25, 8'h01);
    chk_reg({pfx, "_year"},  8'h26, 8'h00);
    chk_reg({pfx, "_tsec"},  8'h41, 8'h00);
    chk_reg({pfx, "_tmin"},  8'h42, 8'h00);
    chk_reg({pfx, "_thour"}, 8'h43, 8'h00);
    chk_reg({pfx, "_status"}, 8'h00, 8'h02);
    check_eq({pfx, "_done_pin"}, {7'b0, timer_done}, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;

    // Bus stays released during reset, even with a read requested
    cyc(2);
    check_eq("rst_io_idle", io_port, 8'hFF);
    cs = 1'b0; rd = 1'b0; ad = 1'b1;
    cyc(2);
    check_eq("rst_io_read", io_port, 8'hFF);
    check_eq("rst_done", {7'b0, timer_done}, 8'h00);

    reset_and_halt();
    check_reset_state("boot");

    // Write then read back minutes; bus releases within 3 clocks of RD high
    write_reg(8'h22, 8'h37);
    bus_write(1'b0, 8'h22);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    cyc(4);
    check_eq("rd_min_drive", io_port, 8'h37);
    rd = 1'b1;
    cyc(3);
    check_eq("rd_release", io_port, 8'hFF);
    cs = 1'b1;
    cyc(2);

    // Unmapped address
    chk_reg("unmapped_rd", 8'h7F, 8'h00);
    write_reg(8'h7F, 8'hAA);
    chk_reg("unmapped_sec", 8'h21, 8'h04);
    chk_reg("unmapped_min", 8'h22, 8'h37);
    chk_reg("unmapped_status", 8'h00, 8'h02);
    chk_reg("unmapped_tsec", 8'h41, 8'h00);

    // Full rollover: 57 -> 58 -> 59 -> 00 with every carry
    write_reg(8'h21, 8'h57);
    write_reg(8'h22, 8'h59);
    write_reg(8'h23, 8'h23);
    write_reg(8'h24, 8'h31);
    write_reg(8'h25, 8'h12);
    write_reg(8'h26, 8'h99);
    run_ticks(3);
    chk_reg("roll_sec",   8'h21, 8'h00);
    chk_reg("roll_min",   8'h22, 8'h00);
    chk_reg("roll_hour",  8'h23, 8'h00);
    chk_reg("roll_day",   8'h24, 8'h01);
    chk_reg("roll_month", 8'h25, 8'h01);
    chk_reg("roll_year",  8'h26, 8'h00);

    // Nibble carry and non-BCD passthrough
    write_reg(8'h21, 8'h09);
    run_ticks(3);
    chk_reg("bcd_09_plus3", 8'h21, 8'h12);
    write_reg(8'h21, 8'h3A);
    run_ticks(3);
    chk_reg("nonbcd_3a_plus3", 8'h21, 8'h3D);

    // Halt freezes time; resuming advances one second per 4 clocks
    write_reg(8'h00, 8'h02);
    write_reg(8'h21, 8'h10);
    cyc(20);
    chk_reg("halt_sec", 8'h21, 8'h10);
    run_ticks(3);
    chk_reg("resume_sec", 8'h21, 8'h13);

    // Timer borrow chain: 01:00:00 minus 3 s
    write_reg(8'h43, 8'h01);
    write_reg(8'h42, 8'h00);
    write_reg(8'h41, 8'h00);
    run_ticks(3);
    chk_reg("borrow_thour", 8'h43, 8'h00);
    chk_reg("borrow_tmin",  8'h42, 8'h59);
    chk_reg("borrow_tsec",  8'h41, 8'h57);
    check_eq("borrow_done", {7'b0, timer_done}, 8'h00);

    // Timer expiry after 60 s, then software clear
    write_reg(8'h43, 8'h00);
    write_reg(8'h42, 8'h01);
    write_reg(8'h41, 8'h00);
    run_ticks(60);
    chk_reg("expire_thour", 8'h43, 8'h00);
    chk_reg("expire_tmin",  8'h42, 8'h00);
    chk_reg("expire_tsec",  8'h41, 8'h00);
    check_eq("expire_done", {7'b0, timer_done}, 8'h01);
    chk_reg("expire_status", 8'h00, 8'h03);
    write_reg(8'h00, 8'h01);
    check_eq("clear_done", {7'b0, timer_done}, 8'h00);
    // 24-clock window keeps the prescaler parked at 3; zero timer must stay idle
    cyc(2);
    write_reg(8'h00, 8'h02);
    chk_reg("idle_tsec", 8'h41, 8'h00);
    check_eq("idle_done", {7'b0, timer_done}, 8'h00);

    // Expiry tick coincides with a STATUS write that also clears: set wins.
    // Unhalt at E, ticks at E+1/5/9/13, the 0x03 write lands at E+13.
    write_reg(8'h41, 8'h04);
    bus_write(1'b0, 8'h00);
    bus_write(1'b1, 8'h00);
    cyc(2);
    bus_write(1'b1, 8'h03);
    check_eq("setwins_done", {7'b0, timer_done}, 8'h01);
    chk_reg("setwins_tsec", 8'h41, 8'h00);
    chk_reg("setwins_status", 8'h00, 8'h03);

    // Reset in the middle of a data-phase write to minutes
    bus_write(1'b0, 8'h22);
    cs = 1'b0; ad = 1'b1; bus_oe = 1'b1; bus_drv = 8'h55;
    cyc(2);
    wr = 1'b0;
    cyc(2);
    reset_and_halt();
    check_reset_state("abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
